sm_multiplier: RTL and testbench

Sequential sign-magnitude multiplier for the convolution datapath. It takes one pixel and one weight, each WIDTH bits wide, per valid/ready transaction. It computes the product with a shift-and-add loop over the magnitude bits. The result is a 2*WIDTH-bit sign-magnitude word, the exact operand format of the convolution adder. The block sits between the operand fetch stage and the adder tree, as the producer of the adder's inputs.

---
 rtl/sm_multiplier.sv | 72 +++++++
 tb/tb_sm_multiplier.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_multiplier.sv
// sm_multiplier: sequential shift-and-add sign-magnitude multiplier with valid/ready handshakes
module sm_multiplier #(
    parameter int WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);
    localparam int MW = 2*WIDTH-2;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_next;
    logic [MW-1:0]   mc, acc, acc_sum;
    logic [WIDTH-2:0] mp;
    logic            sign;
    logic [CW-1:0]   cnt;
    logic            last;

    assign acc_sum   = acc + (mp[0] ? mc : '0);
    assign last      = cnt == CW'(WIDTH-2);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    // state register; reset wins over any handshake in the same cycle
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // next state: accept in IDLE, run WIDTH-1 steps in CALC, hold result in DONE until taken
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = in_valid ? CALC : IDLE;
            CALC:    state_next = last ? DONE : CALC;
            DONE:    state_next = out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    // datapath: latch operands, one shift-and-add step per cycle, register the final product
    always_ff @(posedge clk) begin
        if (rst) begin
            mc      <= '0;
            mp      <= '0;
            sign    <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (state == IDLE && in_valid) begin
            mc   <= MW'(a[WIDTH-2:0]);
            mp   <= b[WIDTH-2:0];
            sign <= a[WIDTH-1] ^ b[WIDTH-1];
            acc  <= '0;
            cnt  <= '0;
        end else if (state == CALC) begin
            acc <= acc_sum;
            mc  <= mc << 1;
            mp  <= mp >> 1;
            cnt <= cnt + CW'(1);
            if (last) product <= {sign && (acc_sum != '0), 1'b0, acc_sum};
        end
    end
endmodule

// File: tb/tb_sm_multiplier.sv
// tb_sm_multiplier: randomized and directed checks of sm_multiplier against an arithmetic model
module tb_sm_multiplier;
    localparam int W = 9;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] product;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0]   da [6] = '{9'h005, 9'h105, 9'h105, 9'h1FF, 9'h100, 9'h000};
    logic [W-1:0]   db [6] = '{9'h007, 9'h007, 9'h107, 9'h1FF, 9'h003, 9'h1FF};
    logic [2*W-1:0] dp [6] = '{18'h00023, 18'h20023, 18'h00023, 18'h0FE01, 18'h00000, 18'h00000};

    sm_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );

    always #5 clk = ~clk;

    // Model: multiply magnitudes as integers, sign is XOR unless the result is zero.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        longint m;
        logic   s;
        m = longint'(x[W-2:0]) * longint'(y[W-2:0]);
        s = (x[W-1] ^ y[W-1]) && (m != 0);
        return {s, 1'b0, (2*W-2)'(m)};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic jitter;
        in_valid = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
    endtask

    // Drives one transaction; stalls out_ready for 'stall' cycles while scrambling inputs.
    // Returns the product, the cycles from acceptance to out_valid, and whether output held steady.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input int stall,
                          output logic [2*W-1:0] got, output int lat, output bit stable);
        int n = 0;
        a = xa;
        b = xb;
        in_valid = 1'b1;
        out_ready = (stall == 0);
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        step();
        lat = 1;
        jitter();
        while (!out_valid && lat < 100) begin
            step();
            lat++;
            jitter();
        end
        got = product;
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            step();
            jitter();
            if (product !== got || !out_valid || in_ready) stable = 1'b0;
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        jitter();
        step();
        step();
        vectors++;
        if ({in_ready, out_valid, product} !== {1'b1, 1'b0, {2*W{1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b product=%h, want 1 0 0",
                     in_ready, out_valid, product);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_directed;
        logic [2*W-1:0] got;
        int lat;
        bit st;
        for (int i = 0; i < 6; i++) begin
            run_op(da[i], db[i], 0, got, lat, st);
            vectors++;
            if (got !== dp[i]) begin
                miscompares++;
                $display("FAIL directed_product[%0d]: %h*%h got %h want %h", i, da[i], db[i], got, dp[i]);
            end
            vectors++;
            if (lat !== W) begin
                miscompares++;
                $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, W);
            end
            vectors++;
            if ({in_ready, out_valid} !== 2'b10) begin
                miscompares++;
                $display("FAIL directed_after_handshake[%0d]: in_ready=%b out_valid=%b want 1 0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [2*W-1:0] got;
        int lat;
        bit st;
        run_op(9'h10B, 9'h00D, 5, got, lat, st);
        vectors++;
        if (got !== ref_mul(9'h10B, 9'h00D)) begin
            miscompares++;
            $display("FAIL bp_product: got %h want %h", got, ref_mul(9'h10B, 9'h00D));
        end
        vectors++;
        if (!st) begin
            miscompares++;
            $display("FAIL bp_hold: product/out_valid/in_ready changed during stall, got 0 want 1");
        end
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL bp_single_delivery: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        run_op(9'h003, 9'h109, 0, got, lat, st);
        vectors++;
        if (got !== ref_mul(9'h003, 9'h109) || lat !== W) begin
            miscompares++;
            $display("FAIL bp_next_op: got %h lat %0d want %h lat %0d", got, lat, ref_mul(9'h003, 9'h109), W);
        end
    endtask

    task automatic test_reset_mid;
        logic [2*W-1:0] got;
        int lat;
        bit st;
        bit emitted = 1'b0;
        a = 9'h002;
        b = 9'h003;
        in_valid = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_ready: in_ready=%b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if ({in_ready, out_valid, product} !== {1'b1, 1'b0, {2*W{1'b0}}}) begin
            miscompares++;
            $display("FAIL rmid_state: in_ready=%b out_valid=%b product=%h want 1 0 0",
                     in_ready, out_valid, product);
        end
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid) emitted = 1'b1;
        end
        vectors++;
        if (emitted !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_no_emit: emitted=%b want 0", emitted);
        end
        run_op(9'h004, 9'h006, 0, got, lat, st);
        vectors++;
        if (got !== 18'h00018 || lat !== W) begin
            miscompares++;
            $display("FAIL rmid_after: got %h lat %0d want 00018 lat %0d", got, lat, W);
        end
    endtask

    task automatic test_back_to_back;
        logic [2*W-1:0] got;
        logic [W-1:0] xa, xb;
        int lat;
        bit st;
        for (int i = 0; i < 40; i++) begin
            xa = W'($urandom);
            xb = W'($urandom);
            if (i % 8 == 0) xa[W-2:0] = '0;
            run_op(xa, xb, int'($urandom_range(0, 3)), got, lat, st);
            vectors++;
            if (got !== ref_mul(xa, xb) || lat !== W || !st) begin
                miscompares++;
                $display("FAIL rand[%0d]: %h*%h got %h lat %0d stable %b want %h lat %0d stable 1",
                         i, xa, xb, got, lat, st, ref_mul(xa, xb), W);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
